radial_line_sequencer: RTL and testbench
========================================

RADIAL_LINE_SEQUENCER -- requirements
Module: radial_line_sequencer

Interface
REQ-001 Parameters (name, default, meaning), one per line:
 - XW, 10, x coordinate width.
 - YW, 9, y coordinate width.
 - NUM_POS, 12, number of spoke positions, 2..64.
 - HOLD_CYCLES, 128, clocks a drawn spoke is held before erase, >=1.
 - CX, 200, spoke centre x.
 - CY, 200, spoke centre y.
REQ-002 Ports (name, direction, width, meaning), one per line, clock and reset first:
 - clk, in, 1, clock.
 - reset, in, 1, synchronous, active-high.
 - enable, in, 1, run the animation.
 - step_dir, in, 1, 0 = index increments, 1 = index decrements.
 - trail_mode, in, 1, 1 = skip erase and leave spokes drawn.
 - ld_done, in, 1, one-cycle pulse from the line drawer when a line is complete.
 - ld_start, out, 1, one-cycle request to the line drawer.
 - x0, out, XW, line start x.
 - y0, out, YW, line start y.
 - x1, out, XW, line end x.
 - y1, out, YW, line end y.
 - pixel_color, out, 1, 1 = draw, 0 = erase.
 - pos_idx, out, $clog2(NUM_POS), current spoke index.
 - frame_done, out, 1, one-cycle pulse on index wrap.
 - busy, out, 1, high in every state except IDLE.

Function
REQ-003 FSM states: IDLE, DRAW_REQ, DRAW_WAIT, HOLD, ERASE_REQ, ERASE_WAIT, ADVANCE.
REQ-004 IDLE -> DRAW_REQ when enable=1; otherwise remain in IDLE.
REQ-005 DRAW_REQ lasts exactly 1 cycle with ld_start=1 and pixel_color=1, then goes to DRAW_WAIT.
REQ-006 DRAW_WAIT -> HOLD on ld_done=1.
REQ-007 HOLD counts HOLD_CYCLES clocks; on the last count it goes to ADVANCE if trail_mode=1, else to ERASE_REQ.
REQ-008 ERASE_REQ lasts 1 cycle with ld_start=1 and pixel_color=0, then goes to ERASE_WAIT.
REQ-009 ERASE_WAIT -> ADVANCE on ld_done=1.
REQ-010 ADVANCE lasts 1 cycle and updates pos_idx, then goes to DRAW_REQ if enable=1, else to IDLE.
REQ-011 In ADVANCE, step_dir=0 sets pos_idx to (pos_idx+1) mod NUM_POS; step_dir=1 sets it to (pos_idx-1) mod NUM_POS.
REQ-012 frame_done pulses in ADVANCE for the NUM_POS-1 -> 0 wrap (step_dir=0) and the 0 -> NUM_POS-1 wrap (step_dir=1).
REQ-013 x0/y0 = (CX,CY); x1/y1 = endpoint for pos_idx, registered on entry to DRAW_REQ.
REQ-014 x0, y0, x1, y1 hold constant from DRAW_REQ through the end of ERASE_WAIT.
REQ-015 pixel_color holds its value from each REQ state until the matching ld_done.
REQ-016 ld_done arriving outside DRAW_WAIT/ERASE_WAIT is ignored.
REQ-017 ld_done in the same cycle as ld_start is ignored; a WAIT state needs ld_done on a later cycle.
REQ-018 Deasserting enable mid-cycle does not abort: the current draw, hold and erase complete, and the FSM stops at the next ADVANCE.
REQ-019 step_dir and trail_mode are sampled only in ADVANCE and HOLD respectively; changes elsewhere take effect at the next sample point.
REQ-020 Endpoints lie on a circle about (CX,CY), spaced 360/NUM_POS degrees, index 0 at 12 o'clock, increasing clockwise.
REQ-021 The radius is min(CX,CY)-10, and the stored values are rounded to integer and saturated to the XW/YW ranges.

Reset
REQ-022 On reset the block enters IDLE and sets: pos_idx=0, hold counter=0, ld_start=0, pixel_color=0, frame_done=0, busy=0, x0=CX, y0=CY, x1=CX, y1=CY.
REQ-023 reset mid-line takes effect next cycle with no erase issued; an orphaned drawn spoke is acceptable.

Structure
REQ-024 The shared package line_pkg holds the state enum type, the XW/YW defaults, and the coord_t struct {x,y}.
REQ-025 Sub-module spoke_rom(idx -> coord_t) is combinational and generated from the parameters.
REQ-026 The hold counter width is $clog2(HOLD_CYCLES+1).

Verification
REQ-027 Reset, enable=1, ld_done returned 5 cycles after each ld_start -> first ld_start at cycle 2, with x1=200, y1=10, pixel_color=1.
REQ-028 HOLD_CYCLES=4, trail_mode=0 -> erase ld_start exactly 4 cycles after draw ld_done, with identical coordinates and pixel_color=0.
REQ-029 NUM_POS=12, step_dir=0, full run -> pos_idx sequence 0..11,0 and a single frame_done at the 11 -> 0 step.
REQ-030 step_dir=1 from reset -> pos_idx goes 0 -> 11 with frame_done=1 on that step.
REQ-031 trail_mode=1 -> no pixel_color=0 request for the whole frame; 12 ld_start pulses per frame.
REQ-032 enable dropped during DRAW_WAIT -> the erase still occurs, then IDLE with busy=0, and no further ld_start; reset asserted in HOLD -> IDLE next cycle with pos_idx=0.

Source files
------------

// File: rtl/line_pkg.sv
// Shared types for the radial line sequencer: FSM state encoding, default
// coordinate widths and the packed point type passed from the spoke table.
package line_pkg;

  localparam int DEF_XW = 10;
  localparam int DEF_YW = 9;

  typedef enum logic [2:0] {
    IDLE,
    DRAW_REQ,
    DRAW_WAIT,
    HOLD,
    ERASE_REQ,
    ERASE_WAIT,
    ADVANCE
  } state_t;

  typedef struct packed {
    logic [DEF_XW-1:0] x;
    logic [DEF_YW-1:0] y;
  } coord_t;

endpackage

// File: rtl/spoke_rom.sv
// Combinational spoke endpoint table built at elaboration: NUM_POS points on a
// circle about (CX,CY), index 0 at 12 o'clock, stepping clockwise.
module spoke_rom
  import line_pkg::*;
#(
  parameter int XW      = DEF_XW,
  parameter int YW      = DEF_YW,
  parameter int NUM_POS = 12,
  parameter int CX      = 200,
  parameter int CY      = 200
) (
  input  logic [$clog2(NUM_POS)-1:0] idx,
  output coord_t                     pt
);

  localparam real TWO_PI = 6.283185307179586;
  localparam int  RADIUS = ((CX < CY) ? CX : CY) - 10;
  localparam int  XMAX   = (1 << XW) - 1;
  localparam int  YMAX   = (1 << YW) - 1;

  coord_t table_c [NUM_POS];

  // Screen y grows downward, so 12 o'clock is CY-R and clockwise moves +x first.
  for (genvar i = 0; i < NUM_POS; i++) begin : g_spoke
    localparam real ANG = TWO_PI * i / NUM_POS;
    localparam real XR  = CX + RADIUS * $sin(ANG);
    localparam real YR  = CY - RADIUS * $cos(ANG);
    localparam int  XI  = (XR >= 0.0) ? $rtoi(XR + 0.5) : -$rtoi(0.5 - XR);
    localparam int  YI  = (YR >= 0.0) ? $rtoi(YR + 0.5) : -$rtoi(0.5 - YR);
    localparam int  XS  = (XI < 0) ? 0 : ((XI > XMAX) ? XMAX : XI);
    localparam int  YS  = (YI < 0) ? 0 : ((YI > YMAX) ? YMAX : YI);

    assign table_c[i].x = DEF_XW'(XS);
    assign table_c[i].y = DEF_YW'(YS);
  end

  assign pt = (int'(idx) < NUM_POS) ? table_c[idx] : table_c[0];

endmodule

// File: rtl/radial_line_sequencer.sv
// Rotating-spoke animator: requests a line from the centre to each spoke
// endpoint, holds it, optionally erases it, then steps to the next spoke.
module radial_line_sequencer
  import line_pkg::*;
#(
  parameter int XW          = DEF_XW,
  parameter int YW          = DEF_YW,
  parameter int NUM_POS     = 12,
  parameter int HOLD_CYCLES = 128,
  parameter int CX          = 200,
  parameter int CY          = 200
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       enable,
  input  logic                       step_dir,
  input  logic                       trail_mode,
  input  logic                       ld_done,
  output logic                       ld_start,
  output logic [XW-1:0]              x0,
  output logic [YW-1:0]              y0,
  output logic [XW-1:0]              x1,
  output logic [YW-1:0]              y1,
  output logic                       pixel_color,
  output logic [$clog2(NUM_POS)-1:0] pos_idx,
  output logic                       frame_done,
  output logic                       busy
);

  localparam int              IW        = $clog2(NUM_POS);
  localparam int              HW        = $clog2(HOLD_CYCLES + 1);
  localparam logic [IW-1:0]   LAST_IDX  = IW'(NUM_POS - 1);
  localparam logic [HW-1:0]   HOLD_LAST = HW'(HOLD_CYCLES - 1);

  state_t        state;
  logic [HW-1:0] hold_cnt;
  logic [IW-1:0] adv_idx;
  logic [IW-1:0] rom_idx;
  coord_t        rom_pt;

  always_comb begin
    adv_idx = pos_idx;
    if (step_dir) adv_idx = (pos_idx == '0) ? LAST_IDX : pos_idx - 1'b1;
    else          adv_idx = (pos_idx == LAST_IDX) ? '0 : pos_idx + 1'b1;
  end

  // Leaving ADVANCE loads the endpoint of the index being stepped to.
  assign rom_idx = (state == ADVANCE) ? adv_idx : pos_idx;

  spoke_rom #(
    .XW(XW), .YW(YW), .NUM_POS(NUM_POS), .CX(CX), .CY(CY)
  ) u_rom (
    .idx(rom_idx),
    .pt (rom_pt)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      pos_idx     <= '0;
      hold_cnt    <= '0;
      ld_start    <= 1'b0;
      pixel_color <= 1'b0;
      frame_done  <= 1'b0;
      busy        <= 1'b0;
      x0          <= XW'(CX);
      y0          <= YW'(CY);
      x1          <= XW'(CX);
      y1          <= YW'(CY);
    end else begin
      ld_start   <= 1'b0;
      frame_done <= 1'b0;
      unique case (state)
        IDLE: begin
          if (enable) begin
            state       <= DRAW_REQ;
            ld_start    <= 1'b1;
            pixel_color <= 1'b1;
            busy        <= 1'b1;
            x0          <= XW'(CX);
            y0          <= YW'(CY);
            x1          <= XW'(rom_pt.x);
            y1          <= YW'(rom_pt.y);
          end
        end
        DRAW_REQ: state <= DRAW_WAIT;
        // The completion clock counts as the first hold clock.
        DRAW_WAIT: begin
          if (ld_done) begin
            state    <= HOLD;
            hold_cnt <= HW'(1);
          end
        end
        HOLD: begin
          if (hold_cnt >= HOLD_LAST) begin
            hold_cnt <= '0;
            if (trail_mode) begin
              state <= ADVANCE;
            end else begin
              state       <= ERASE_REQ;
              ld_start    <= 1'b1;
              pixel_color <= 1'b0;
            end
          end else begin
            hold_cnt <= hold_cnt + 1'b1;
          end
        end
        ERASE_REQ: state <= ERASE_WAIT;
        ERASE_WAIT: if (ld_done) state <= ADVANCE;
        ADVANCE: begin
          pos_idx    <= adv_idx;
          frame_done <= step_dir ? (pos_idx == '0) : (pos_idx == LAST_IDX);
          if (enable) begin
            state       <= DRAW_REQ;
            ld_start    <= 1'b1;
            pixel_color <= 1'b1;
            x0          <= XW'(CX);
            y0          <= YW'(CY);
            x1          <= XW'(rom_pt.x);
            y1          <= YW'(rom_pt.y);
          end else begin
            state <= IDLE;
            busy  <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_radial_line_sequencer.sv
// Scoreboard bench for radial_line_sequencer: a driver plays the line drawer
// and queues expected requests/steps, a monitor pops and compares them.
module tb_radial_line_sequencer;

  localparam int XW          = 10;
  localparam int YW          = 9;
  localparam int NUM_POS     = 12;
  localparam int HOLD_CYCLES = 4;
  localparam int CX          = 200;
  localparam int CY          = 200;
  localparam int IW          = $clog2(NUM_POS);
  localparam int N_SPOKES    = 40;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          enable = 1'b0;
  logic          step_dir = 1'b0;
  logic          trail_mode = 1'b0;
  logic          ld_done = 1'b0;
  logic          ld_start;
  logic [XW-1:0] x0, x1;
  logic [YW-1:0] y0, y1;
  logic          pixel_color;
  logic [IW-1:0] pos_idx;
  logic          frame_done;
  logic          busy;

  typedef struct {int color; int x1; int y1; int idx;} req_t;
  typedef struct {int idx; int wrap;} adv_t;

  req_t exp_req[$];
  adv_t exp_adv[$];

  int cyc = 0;
  int checks = 0;
  int errors = 0;
  int model_idx = 0;
  int prev_idx = 0;
  int done_cyc = 0;
  int rst_cyc = 0;
  bit mon_on = 1'b0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  radial_line_sequencer #(
    .XW(XW), .YW(YW), .NUM_POS(NUM_POS), .HOLD_CYCLES(HOLD_CYCLES), .CX(CX), .CY(CY)
  ) dut (
    .clk(clk), .reset(reset), .enable(enable), .step_dir(step_dir),
    .trail_mode(trail_mode), .ld_done(ld_done), .ld_start(ld_start),
    .x0(x0), .y0(y0), .x1(x1), .y1(y1), .pixel_color(pixel_color),
    .pos_idx(pos_idx), .frame_done(frame_done), .busy(busy)
  );

  task automatic checkOutput(input string name, input longint actual, input longint expected);
    checks++;
    if (actual != expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0d, expected %0d (cycle %0d)", name, actual, expected, cyc);
    end
  endtask

  task automatic finishRun();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  endtask

  // Endpoint from circle geometry: angle measured clockwise from 12 o'clock.
  function automatic req_t spoke_req(input int idx, input int color);
    req_t r;
    real  ang, rad, xr, yr;
    int   xi, yi;
    rad = ((CX < CY) ? CX : CY) - 10;
    ang = 2.0 * 3.141592653589793 * idx / NUM_POS;
    xr  = CX + rad * $sin(ang);
    yr  = CY - rad * $cos(ang);
    xi  = int'(xr);
    yi  = int'(yr);
    if (xi < 0) xi = 0;
    if (xi > (1 << XW) - 1) xi = (1 << XW) - 1;
    if (yi < 0) yi = 0;
    if (yi > (1 << YW) - 1) yi = (1 << YW) - 1;
    r.color = color;
    r.x1    = xi;
    r.y1    = yi;
    r.idx   = idx;
    return r;
  endfunction

  task automatic wait_start(input string what);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!ld_start && n < 100);
    if (!ld_start) begin
      checks++;
      errors++;
      $display("[TB] FAIL timeout_%s: got no ld_start, expected one within 100 cycles", what);
      finishRun();
    end
  endtask

  // Line-drawer response: optional early pulse in the request cycle, then the real one.
  task automatic pulse_done(input int lat, input bit early);
    if (early) ld_done = 1'b1;
    for (int i = 0; i < lat; i++) begin
      @(negedge clk);
      ld_done = 1'b0;
    end
    ld_done  = 1'b1;
    done_cyc = cyc;
    @(negedge clk);
    ld_done = 1'b0;
  endtask

  // Called at the negedge where a draw request is visible; plays one spoke.
  task automatic applyStimulus(input int trail, input int dir, input int lat, input bit last);
    int nxt, wrap;
    nxt  = dir ? (model_idx + NUM_POS - 1) % NUM_POS : (model_idx + 1) % NUM_POS;
    wrap = dir ? int'(model_idx == 0) : int'(model_idx == NUM_POS - 1);
    trail_mode = trail[0];
    step_dir   = dir[0];
    if (trail == 0) exp_req.push_back(spoke_req(model_idx, 0));
    exp_adv.push_back('{idx: nxt, wrap: wrap});
    if (!last) exp_req.push_back(spoke_req(nxt, 1));
    model_idx = nxt;
    if (last) begin
      @(negedge clk);
      enable = 1'b0;
      pulse_done(lat, 1'b0);
    end else begin
      pulse_done(lat, 1'($urandom_range(0, 1)));
    end
    @(negedge clk);
    ld_done = 1'b1;
    @(negedge clk);
    ld_done = 1'b0;
    if (trail == 0) begin
      wait_start("erase");
      checkOutput("erase_gap", cyc - done_cyc, HOLD_CYCLES);
      pulse_done($urandom_range(1, 6), 1'($urandom_range(0, 1)));
    end
  endtask

  // Monitor: every request and every index step is matched against the queues.
  initial begin
    req_t e;
    adv_t a;
    forever begin
      @(negedge clk);
      if (mon_on) begin
        if (ld_start) begin
          if (exp_req.size() == 0) begin
            checks++;
            errors++;
            $display("[TB] FAIL unexpected_request: got ld_start color %0d idx %0d, expected none",
                     pixel_color, pos_idx);
          end else begin
            e = exp_req.pop_front();
            checkOutput("req_color", pixel_color, e.color);
            checkOutput("req_idx", pos_idx, e.idx);
            checkOutput("req_x1", x1, e.x1);
            checkOutput("req_y1", y1, e.y1);
            checkOutput("req_x0", x0, CX);
            checkOutput("req_y0", y0, CY);
          end
        end
        if (int'(pos_idx) != prev_idx || frame_done) begin
          if (exp_adv.size() == 0) begin
            checks++;
            errors++;
            $display("[TB] FAIL unexpected_step: got idx %0d frame_done %0d, expected no change",
                     pos_idx, frame_done);
          end else begin
            a = exp_adv.pop_front();
            checkOutput("step_idx", pos_idx, a.idx);
            checkOutput("frame_done", frame_done, a.wrap);
          end
        end
        prev_idx = int'(pos_idx);
      end
    end
  end

  initial begin
    #200000;
    checks++;
    errors++;
    $display("[TB] FAIL watchdog: got no completion, expected finish within 20000 cycles");
    finishRun();
  end

  initial begin
    int trail, dir, lat;
    repeat (3) @(negedge clk);
    reset   = 1'b1;
    enable  = 1'b1;
    rst_cyc = cyc;
    model_idx = 0;
    exp_req.push_back(spoke_req(0, 1));
    @(negedge clk);
    reset = 1'b0;
    checkOutput("reset_busy", busy, 0);
    checkOutput("reset_idx", pos_idx, 0);
    checkOutput("reset_ld_start", ld_start, 0);
    checkOutput("reset_color", pixel_color, 0);
    checkOutput("reset_frame_done", frame_done, 0);
    checkOutput("reset_x0", x0, CX);
    checkOutput("reset_y0", y0, CY);
    checkOutput("reset_x1", x1, CX);
    checkOutput("reset_y1", y1, CY);
    prev_idx = 0;
    mon_on   = 1'b1;

    wait_start("first_draw");
    checkOutput("first_start_cycle", cyc - rst_cyc, 2);
    checkOutput("first_x1", x1, 200);
    checkOutput("first_y1", y1, 10);
    checkOutput("first_color", pixel_color, 1);

    // Frame 1 erases going forward, frame 2 trails, then one backward wrap, then random.
    for (int k = 0; k < N_SPOKES; k++) begin
      if (k > 0) wait_start("draw");
      if (k < NUM_POS) begin
        trail = 0; dir = 0; lat = 5;
      end else if (k < 2 * NUM_POS) begin
        trail = 1; dir = 0; lat = $urandom_range(1, 6);
      end else if (k == 2 * NUM_POS) begin
        trail = 0; dir = 1; lat = $urandom_range(1, 6);
      end else begin
        trail = $urandom_range(0, 1); dir = $urandom_range(0, 1); lat = $urandom_range(1, 6);
      end
      if (k == N_SPOKES - 1) trail = 0;
      applyStimulus(trail, dir, lat, k == N_SPOKES - 1);
    end

    repeat (20) @(negedge clk);
    checkOutput("stopped_busy", busy, 0);
    checkOutput("stopped_idx", pos_idx, model_idx);

    enable     = 1'b1;
    trail_mode = 1'b0;
    exp_req.push_back(spoke_req(model_idx, 1));
    wait_start("restart_draw");
    pulse_done(3, 1'b0);
    if (model_idx != 0) exp_adv.push_back('{idx: 0, wrap: 0});
    reset  = 1'b1;
    enable = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    model_idx = 0;
    checkOutput("hold_reset_busy", busy, 0);
    checkOutput("hold_reset_idx", pos_idx, 0);
    checkOutput("hold_reset_ld_start", ld_start, 0);
    checkOutput("hold_reset_color", pixel_color, 0);
    checkOutput("hold_reset_x1", x1, CX);
    repeat (15) @(negedge clk);
    checkOutput("pending_requests", exp_req.size(), 0);
    checkOutput("pending_steps", exp_adv.size(), 0);
    finishRun();
  end

endmodule
